// File: rtl/ysyx_22040127_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040127_mem_stage_pkg
// Brief   : Shared bus layouts, memop encodings and FSM codes for the MEM stage
// Revision: 1.0
// ============================================================================
package ysyx_22040127_mem_stage_pkg;

    localparam int c_EX_TO_MEM_WIDTH = 172;
    localparam int c_MEM_TO_WB_WIDTH = 102;

    // Field order matches the EX->MEM bus from MSB to LSB.
    typedef struct packed {
        logic        jalr;
        logic [31:0] pc;
        logic [2:0]  memop;
        logic        reg_wen;
        logic        memwrite;
        logic        memread;
        logic [4:0]  rd;
        logic [63:0] alu_res;
        logic [63:0] st_data;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [63:0] result;
    } mem_to_wb_t;

    localparam logic [2:0] c_MEMOP_B  = 3'b000;
    localparam logic [2:0] c_MEMOP_H  = 3'b001;
    localparam logic [2:0] c_MEMOP_W  = 3'b010;
    localparam logic [2:0] c_MEMOP_D  = 3'b011;
    localparam logic [2:0] c_MEMOP_BU = 3'b100;
    localparam logic [2:0] c_MEMOP_HU = 3'b101;
    localparam logic [2:0] c_MEMOP_WU = 3'b110;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // memop[1:0] encodes the access size; 111 falls into the doubleword case.
    function automatic logic [7:0] size_mask(input logic [2:0] memop);
        case (memop[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] memop, input logic [2:0] off);
        case (memop[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040127_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040127_mem_stage_if
// Brief   : Data-memory request/response port (req/ready, rvalid/rdata)
// Revision: 1.0
// ============================================================================
interface ysyx_22040127_mem_stage_if;
    logic        req;
    logic        ready;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        rvalid;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, wmask, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, wmask, output ready, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/ysyx_22040127_mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040127_load_align
// Brief   : Selects the addressed bytes of a doubleword and sign/zero extends
// Revision: 1.0
// ============================================================================
module ysyx_22040127_load_align
    import ysyx_22040127_mem_stage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  memop,
    output logic [63:0] data
);

    logic [63:0] w_shifted;

    assign w_shifted = rdata >> {off, 3'b000};

    always_comb begin
        data = w_shifted;
        case (memop)
            c_MEMOP_B:  data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            c_MEMOP_H:  data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            c_MEMOP_W:  data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            c_MEMOP_BU: data = {56'd0, w_shifted[7:0]};
            c_MEMOP_HU: data = {48'd0, w_shifted[15:0]};
            c_MEMOP_WU: data = {32'd0, w_shifted[31:0]};
            default:    data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040127_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040127_mem_stage
// Brief   : MEM pipeline stage; issues loads/stores on the data-memory port
// Revision: 1.0
// ============================================================================
module ysyx_22040127_mem_stage
    import ysyx_22040127_mem_stage_pkg::*;
#(
    parameter int EX_TO_MEM_WIDTH = c_EX_TO_MEM_WIDTH,
    parameter int MEM_TO_WB_WIDTH = c_MEM_TO_WB_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_to_mem_valid,
    output logic                       mem_allowin,
    input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
    input  logic                       wb_allowin,
    output logic                       mem_to_wb_valid,
    output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
    ysyx_22040127_mem_stage_if.master  dmem,
    output logic                       mem_fwd_valid,
    output logic                       mem_fwd_ready,
    output logic [4:0]                 mem_fwd_rd,
    output logic                       mem_misalign
);

    ex_to_mem_t  w_in;
    ex_to_mem_t  r_bus;
    mem_to_wb_t  w_out;
    logic        r_mem_valid;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [63:0] r_rdata;
    logic        r_misalign;
    logic [2:0]  w_off;
    logic        w_is_mem;
    logic        w_misal;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_in_is_mem;
    logic        w_in_misal;
    logic        w_in_go;
    logic        w_is_load;
    logic        w_reg_wen;
    logic [63:0] w_load_data;
    logic        w_unused;

    assign w_in        = ex_to_mem_bus;
    assign w_off       = r_bus.alu_res[2:0];
    assign w_is_mem    = r_bus.memread | r_bus.memwrite;
    assign w_misal     = w_is_mem & misaligned(r_bus.memop, w_off);
    // A suppressed misaligned access completes immediately like a non-memory op.
    assign w_ready_go  = ~w_is_mem | w_misal | (r_state == c_ST_DONE);

    assign mem_allowin     = ~r_mem_valid | (w_ready_go & wb_allowin);
    assign mem_to_wb_valid = r_mem_valid & w_ready_go;

    assign w_accept    = ex_to_mem_valid & mem_allowin;
    assign w_in_is_mem = w_in.memread | w_in.memwrite;
    assign w_in_misal  = w_accept & w_in_is_mem & misaligned(w_in.memop, w_in.alu_res[2:0]);
    assign w_in_go     = w_accept & w_in_is_mem & ~misaligned(w_in.memop, w_in.alu_res[2:0]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_in_go)      w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (dmem.ready)   w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (dmem.rvalid)  w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (wb_allowin)   w_state_nxt = w_in_go ? c_ST_REQ : c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_misalign  <= 1'b0;
            r_bus       <= '0;
            r_rdata     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= w_in_misal;
            if (mem_allowin) begin
                r_mem_valid <= ex_to_mem_valid;
            end
            if (w_accept) begin
                r_bus <= w_in;
            end
            if ((r_state == c_ST_WAIT) && dmem.rvalid) begin
                r_rdata <= dmem.rdata;
            end
        end
    end

    assign dmem.req   = (r_state == c_ST_REQ);
    assign dmem.we    = r_bus.memwrite;
    assign dmem.addr  = {r_bus.alu_res[63:3], 3'b000};
    assign dmem.wmask = size_mask(r_bus.memop) << w_off;
    assign dmem.wdata = r_bus.st_data << {w_off, 3'b000};

    ysyx_22040127_load_align u_load_align (
        .rdata (r_rdata),
        .off   (w_off),
        .memop (r_bus.memop),
        .data  (w_load_data)
    );

    assign w_is_load = r_bus.memread & ~w_misal;
    assign w_reg_wen = r_bus.reg_wen & ~w_misal;

    assign w_out.pc      = r_bus.pc;
    assign w_out.reg_wen = w_reg_wen;
    assign w_out.rd      = r_bus.rd;
    assign w_out.result  = w_is_load ? w_load_data : r_bus.alu_res;
    assign mem_to_wb_bus = w_out;

    assign mem_fwd_valid = r_mem_valid & w_reg_wen & (|r_bus.rd);
    assign mem_fwd_ready = ~w_is_load | (r_state == c_ST_DONE);
    assign mem_fwd_rd    = r_bus.rd;
    assign mem_misalign  = r_misalign;

    assign w_unused = r_bus.jalr;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22040127_mem_stage
// Brief   : Scoreboard bench with a byte-level memory reference model
// Revision: 1.0
// ============================================================================
module tb_ysyx_22040127_mem_stage;
    import ysyx_22040127_mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         ex_to_mem_valid, mem_allowin, wb_allowin, mem_to_wb_valid;
    ex_to_mem_t   ex_to_mem_bus;
    logic [101:0] mem_to_wb_bus;
    logic         mem_fwd_valid, mem_fwd_ready, mem_misalign;
    logic [4:0]   mem_fwd_rd;

    ysyx_22040127_mem_stage_if dmem ();

    ysyx_22040127_mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_to_mem_valid (ex_to_mem_valid),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .wb_allowin      (wb_allowin),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .dmem            (dmem),
        .mem_fwd_valid   (mem_fwd_valid),
        .mem_fwd_ready   (mem_fwd_ready),
        .mem_fwd_rd      (mem_fwd_rd),
        .mem_misalign    (mem_misalign)
    );

    typedef struct { logic [101:0] wb; bit ld; logic [4:0] rd; bit fwd; } exp_t;
    typedef struct { logic [63:0] addr; bit we; logic [63:0] wdata; logic [7:0] wmask; } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;

    bit mon_en = 0, mis_pend = 0, req_pend = 0, req_exp = 0;
    bit in_wait = 0, hold_rvalid = 0, bp_mode = 0, wb_always = 1;
    int force_rdly = -1, force_vdly = -1;

    logic [7:0] ref_mem [logic [63:0]];
    logic [7:0] slv_mem [logic [63:0]];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] init_b(input logic [63:0] a);
        return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
    endfunction

    function automatic logic [7:0] slv_rd(input logic [63:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_b(a);
    endfunction

    task automatic poke(input logic [63:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            ref_mem[a + 64'(i)] = v[8*i +: 8];
            slv_mem[a + 64'(i)] = v[8*i +: 8];
        end
    endtask

    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    // Reference: operates on byte addresses, independent of lane shifting.
    task automatic model(input ex_to_mem_t ins, output exp_t e, output bit has_req,
                         output req_t r, output bit mis);
        int          n      = nbytes(ins.memop);
        int          off    = int'(ins.alu_res[2:0]);
        logic [63:0] res    = ins.alu_res;
        logic        wen    = ins.reg_wen;
        bit          is_mem = ins.memread || ins.memwrite;
        logic [63:0] v      = '0;
        mis     = is_mem && ((off % n) != 0);
        has_req = is_mem && !mis;
        r       = '{64'd0, 1'b0, 64'd0, 8'd0};
        if (mis) wen = 1'b0;
        if (has_req) begin
            r.addr  = ins.alu_res - 64'(off);
            r.we    = ins.memwrite;
            r.wmask = 8'(((1 << n) - 1) << off);
            r.wdata = ins.st_data << (8 * off);
            if (ins.memwrite) begin
                for (int i = 0; i < n; i++) ref_mem[ins.alu_res + 64'(i)] = ins.st_data[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(ins.alu_res + 64'(i));
                if (!ins.memop[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
                res = v;
            end
        end
        e.wb  = {ins.pc, wen, ins.rd, res};
        e.ld  = has_req && ins.memread;
        e.rd  = ins.rd;
        e.fwd = wen && (ins.rd != 5'd0);
    endtask

    function automatic ex_to_mem_t mk(input int kind, input logic [2:0] op, input logic [63:0] alu,
                                      input logic [63:0] st, input logic [4:0] rd, input logic wen);
        ex_to_mem_t t;
        t.jalr     = 1'($urandom);
        t.pc       = $urandom;
        t.memop    = op;
        t.reg_wen  = wen;
        t.memwrite = (kind == 2);
        t.memread  = (kind == 1);
        t.rd       = rd;
        t.alu_res  = alu;
        t.st_data  = st;
        return t;
    endfunction

    task automatic issue(input ex_to_mem_t ins);
        exp_t e;
        req_t r;
        bit   hr, mis;
        int   n = 0;
        ex_to_mem_bus   = ins;
        ex_to_mem_valid = 1'b1;
        @(negedge clk);
        while (!mem_allowin && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!mem_allowin) begin
            errors++;
            $display("FAIL accept_timeout actual=allowin_low required=accept");
            ex_to_mem_valid = 1'b0;
            return;
        end
        model(ins, e, hr, r, mis);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        if (hr) req_q.push_back(r);
        mis_pend        = mis;
        req_exp         = hr;
        req_pend        = 1'b1;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t h;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (req_pend) begin
                    check("req_after_accept", 256'(dmem.req), 256'(req_exp));
                    req_pend = 1'b0;
                end
                check("misalign_pulse", 256'(mem_misalign), 256'(mis_pend));
                mis_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    check("allowin_empty", 256'(mem_allowin), 256'd1);
                    check("wb_valid_empty", 256'(mem_to_wb_valid), 256'd0);
                    check("fwd_valid_empty", 256'(mem_fwd_valid), 256'd0);
                end else begin
                    h = exp_q[0];
                    check("fwd_valid", 256'(mem_fwd_valid), 256'(h.fwd));
                    check("fwd_rd", 256'(mem_fwd_rd), 256'(h.rd));
                    check("fwd_ready", 256'(mem_fwd_ready), 256'(!h.ld || mem_to_wb_valid));
                    check("allowin_busy", 256'(mem_allowin), 256'(mem_to_wb_valid && wb_allowin));
                    if (mem_to_wb_valid && wb_allowin) begin
                        check("wb_bus", 256'(mem_to_wb_bus), 256'(h.wb));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : slave
        req_t        r;
        logic [136:0] snap;
        logic [63:0] d;
        int          rdly, vdly;
        dmem.ready  = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = '0;
        forever begin
            @(negedge clk);
            if (dmem.req) begin
                snap = {dmem.addr, dmem.we, dmem.wdata, dmem.wmask};
                rdly = (force_rdly >= 0) ? force_rdly : int'($urandom_range(0, 3));
                vdly = (force_vdly >= 0) ? force_vdly : int'($urandom_range(0, 3));
                d    = '0;
                for (int k = 0; k < rdly; k++) begin
                    @(posedge clk);
                    #1;
                    dmem.rvalid = (($urandom % 3) == 0);
                    dmem.rdata  = {$urandom, $urandom};
                    @(negedge clk);
                    check("req_held", 256'(dmem.req), 256'd1);
                    check("req_stable", 256'({dmem.addr, dmem.we, dmem.wdata, dmem.wmask}), 256'(snap));
                end
                @(posedge clk);
                #1;
                dmem.ready  = 1'b1;
                dmem.rvalid = 1'b0;
                @(negedge clk);
                check("req_stable", 256'({dmem.addr, dmem.we, dmem.wdata, dmem.wmask}), 256'(snap));
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req actual=addr_%0h required=no_request", dmem.addr);
                end else begin
                    r = req_q.pop_front();
                    check("req_fields", 256'({dmem.addr, dmem.we, dmem.wdata, dmem.wmask}),
                          256'({r.addr, r.we, r.wdata, r.wmask}));
                end
                for (int i = 0; i < 8; i++) begin
                    if (dmem.we && dmem.wmask[i]) slv_mem[dmem.addr + 64'(i)] = dmem.wdata[8*i +: 8];
                    d[8*i +: 8] = slv_rd(dmem.addr + 64'(i));
                end
                if (dmem.we) d = {$urandom, $urandom};
                @(posedge clk);
                #1;
                dmem.ready = 1'b0;
                in_wait    = 1'b1;
                for (int k = 0; k < vdly; k++) begin
                    @(posedge clk);
                    #1;
                end
                while (hold_rvalid) begin
                    @(posedge clk);
                    #1;
                end
                dmem.rvalid = 1'b1;
                dmem.rdata  = d;
                in_wait     = 1'b0;
                @(posedge clk);
                #1;
                dmem.rvalid = 1'b0;
                dmem.rdata  = {$urandom, $urandom};
            end
        end
    end

    initial begin : wb_drv
        int low = 0;
        wb_allowin = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_mode && dmem.rvalid) low = 3;
            @(posedge clk);
            #1;
            if (low > 0) begin
                wb_allowin = 1'b0;
                low--;
            end else begin
                wb_allowin = wb_always ? 1'b1 : (($urandom % 4) != 0);
            end
        end
    end

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int n;
        rst             = 1'b1;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_bus   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 256'(mem_to_wb_valid), 256'd0);
        check("rst_req", 256'(dmem.req), 256'd0);
        check("rst_misalign", 256'(mem_misalign), 256'd0);
        check("rst_allowin", 256'(mem_allowin), 256'd1);
        check("rst_fwd_valid", 256'(mem_fwd_valid), 256'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        issue(mk(0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1));
        poke(64'h1000, 64'h0000_0000_8000_0000);
        issue(mk(1, c_MEMOP_B, 64'h1003, 64'd0, 5'd6, 1'b1));
        poke(64'h3000, 64'hBEEF_0000_0000_0000);
        issue(mk(1, c_MEMOP_HU, 64'h3006, 64'd0, 5'd7, 1'b1));
        poke(64'h3800, 64'h8000_0001_0000_0000);
        issue(mk(1, c_MEMOP_WU, 64'h3804, 64'd0, 5'd8, 1'b1));
        issue(mk(2, c_MEMOP_H, 64'h2002, 64'hABCD, 5'd0, 1'b0));
        drain();

        bp_mode    = 1;
        force_rdly = 4;
        force_vdly = 2;
        issue(mk(1, c_MEMOP_D, 64'h3800, 64'd0, 5'd9, 1'b1));
        issue(mk(0, 3'd0, 64'h55, 64'd0, 5'd10, 1'b1));
        drain();
        bp_mode    = 0;
        force_rdly = 0;
        force_vdly = 0;
        issue(mk(1, c_MEMOP_D, 64'h1000, 64'd0, 5'd11, 1'b1));
        issue(mk(1, c_MEMOP_D, 64'h3000, 64'd0, 5'd12, 1'b1));
        issue(mk(1, c_MEMOP_W, 64'h1002, 64'd0, 5'd13, 1'b1));
        drain();

        force_rdly = -1;
        force_vdly = -1;
        wb_always  = 0;
        for (int i = 0; i < 300; i++) begin
            int kind = int'($urandom % 3);
            issue(mk(kind, 3'($urandom), 64'h8000_0000 + 64'($urandom_range(0, 255)),
                     {$urandom, $urandom}, 5'($urandom), (kind == 2) ? 1'b0 : 1'($urandom)));
            if (($urandom % 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        drain();

        wb_always   = 1;
        hold_rvalid = 1;
        issue(mk(1, c_MEMOP_D, 64'h1000, 64'd0, 5'd14, 1'b1));
        n = 0;
        while (!in_wait && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait", 256'(in_wait), 256'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_req", 256'(dmem.req), 256'd0);
        check("midrst_wb_valid", 256'(mem_to_wb_valid), 256'd0);
        check("midrst_allowin", 256'(mem_allowin), 256'd1);
        check("midrst_fwd_valid", 256'(mem_fwd_valid), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
